// File: rtl/fifo_to_gpio.sv
// Pops words from a standard FIFO and serialises each one MSB-first onto an EMIO GPIO bit.
// The PS paces the transfer with a level request line and a bit-banged serial clock.
module fifo_to_gpio #(
  parameter int REQ_BIT     = 0,
  parameter int SCLK_BIT    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int WORD_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       emio_gpio_i,
  output logic [31:0]       emio_gpio_o,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_dout,
  output logic              fifo_rd_en
);

  localparam int CNT_W = $clog2(WORD_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [WORD_W-1:0]  shreg, shreg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic                   sclk_s_d;
  logic                   req_s;
  logic                   sclk_s;
  logic                   sclk_rise;

  logic                   rd_en_q;
  logic [3:0]             out_q;
  logic                   unused_gpio;

  // Only two GPIO bits are consumed; the rest are tied off here.
  assign unused_gpio = ^emio_gpio_i;

  assign req_s     = req_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync  <= '0;
      sclk_sync <= '0;
      sclk_s_d  <= 1'b0;
    end else begin
      req_sync  <= {req_sync[SYNC_STAGES-2:0], emio_gpio_i[REQ_BIT]};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], emio_gpio_i[SCLK_BIT]};
      sclk_s_d  <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (req_s && !fifo_empty) state_n = POP;
      end
      POP: begin
        state_n = LOAD;
      end
      LOAD: begin
        shreg_n = fifo_dout;
        cnt_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        // Dropping req aborts the word and wins over a coincident clock edge.
        if (!req_s) begin
          state_n = IDLE;
        end else if (sclk_rise) begin
          shreg_n = {shreg[WORD_W-2:0], 1'b0};
          cnt_n   = cnt + 1'b1;
          if (cnt == CNT_W'(WORD_W - 1)) state_n = DONE;
        end
      end
      DONE: begin
        if (!req_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Every output is a flop so the PS never sees a combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q <= 1'b0;
      out_q   <= '0;
    end else begin
      rd_en_q  <= (state_n == POP);
      out_q[0] <= (state == SHIFT) & shreg[WORD_W-1];
      out_q[1] <= (state == SHIFT);
      out_q[2] <= fifo_empty;
      out_q[3] <= (state != IDLE);
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign emio_gpio_o = {28'b0, out_q};

endmodule

// File: tb/tb_fifo_to_gpio.sv
// Self-checking bench for fifo_to_gpio: a FIFO model feeds words and a PS model
// bit-bangs req/sclk; serial bits are checked against the words pushed.
module tb_fifo_to_gpio;
  localparam int WORD_W      = 32;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              sclk = 1'b0;
  logic [31:0]       emio_gpio_i;
  logic [31:0]       emio_gpio_o;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_dout = '0;
  logic              fifo_rd_en;

  logic [WORD_W-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int underflow = 0;
  int n_checks = 0;
  int n_fail = 0;

  assign emio_gpio_i = {30'b0, sclk, req};
  assign fifo_empty  = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  // Standard (non-FWFT) FIFO: data appears one clock after the pop strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      else begin
        fifo_dout <= mem[rd_ptr[5:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  fifo_to_gpio #(
    .REQ_BIT(0), .SCLK_BIT(1), .SYNC_STAGES(SYNC_STAGES), .WORD_W(WORD_W)
  ) dut (
    .clk(clk), .rst(rst), .emio_gpio_i(emio_gpio_i), .emio_gpio_o(emio_gpio_o),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [WORD_W-1:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_rd_en(input int max, output int lat);
    lat = 0;
    while (lat < max && fifo_rd_en !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // PS side: wait for word_valid, then sample sdata before each sclk rise.
  task automatic shift_word(input logic [WORD_W-1:0] w, input int nbits, input string tag);
    int t;
    logic exp_bit;
    t = 0;
    while (t < 40 && emio_gpio_o[1] !== 1'b1) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (emio_gpio_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s word_valid: got %b want 1", tag, emio_gpio_o[1]);
    end
    for (int i = 0; i < nbits; i++) begin
      exp_bit = w[WORD_W-1-i];
      n_checks++;
      if (emio_gpio_o[0] !== exp_bit) begin
        n_fail++;
        $display("FAIL %s sdata bit %0d: got %b want %b", tag, i, emio_gpio_o[0], exp_bit);
      end
      sclk = 1'b1;
      tick(8);
      sclk = 1'b0;
      tick(8);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic test_reset();
    tick(1);
    check_word("reset emio", emio_gpio_o, 32'h0);
    check_word("reset rd_en", {31'b0, fifo_rd_en}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    check_word("idle empty emio", emio_gpio_o, 32'h4);
  endtask

  task automatic test_single();
    int lat;
    int p0;
    p0 = rd_ptr;
    push(32'hA5C3_0F81);
    tick(2);
    check_word("idle nonempty emio", emio_gpio_o, 32'h0);
    req = 1'b1;
    wait_rd_en(20, lat);
    check_word("req to pop latency", lat, SYNC_STAGES + 1);
    shift_word(32'hA5C3_0F81, 32, "single");
    check_word("single done emio", emio_gpio_o, 32'hC);
    check_word("single pops", rd_ptr - p0, 1);
    req = 1'b0;
    tick(6);
    check_word("single idle emio", emio_gpio_o, 32'h4);
  endtask

  task automatic test_empty_wait();
    int lat;
    int pops_seen;
    int p0;
    p0 = rd_ptr;
    pops_seen = 0;
    req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) pops_seen++;
    end
    check_word("empty no pop", pops_seen, 0);
    check_word("empty flag bit", {31'b0, emio_gpio_o[2]}, 32'h1);
    push(32'h0000_0001);
    wait_rd_en(20, lat);
    n_checks++;
    if (lat < 1 || lat > SYNC_STAGES + 1) begin
      n_fail++;
      $display("FAIL empty to pop latency: got %0d want 1..%0d", lat, SYNC_STAGES + 1);
    end
    shift_word(32'h0000_0001, 32, "lsb_last");
    check_word("lsb_last pops", rd_ptr - p0, 1);
    req = 1'b0;
    tick(6);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = rd_ptr;
    push(32'hFFFF_FFFF);
    push(32'h0000_0000);
    tick(1);
    req = 1'b1;
    shift_word(32'hFFFF_FFFF, 32, "b2b_ones");
    tick(20);
    check_word("b2b held in done pops", rd_ptr - p0, 1);
    check_word("b2b done emio", emio_gpio_o, 32'h8);
    req = 1'b0;
    tick(5);
    req = 1'b1;
    shift_word(32'h0000_0000, 32, "b2b_zeros");
    check_word("b2b pops", rd_ptr - p0, 2);
    req = 1'b0;
    tick(6);
  endtask

  task automatic test_abort();
    int p0;
    int t;
    p0 = rd_ptr;
    push(32'h1234_5678);
    push(32'h9ABC_DEF0);
    tick(1);
    req = 1'b1;
    shift_word(32'h1234_5678, 10, "abort_part");
    req = 1'b0;
    t = 0;
    while (t < 20 && emio_gpio_o[3] !== 1'b0) begin
      @(negedge clk);
      t++;
    end
    // State reaches IDLE after SYNC_STAGES+1 clocks; busy is registered one later.
    n_checks++;
    if (emio_gpio_o[3] !== 1'b0 || t > SYNC_STAGES + 2) begin
      n_fail++;
      $display("FAIL abort to idle: took %0d clks busy=%b want <=%0d busy=0", t, emio_gpio_o[3], SYNC_STAGES + 2);
    end
    check_word("abort pops", rd_ptr - p0, 1);
    tick(3);
    req = 1'b1;
    shift_word(32'h9ABC_DEF0, 32, "after_abort");
    check_word("after abort pops", rd_ptr - p0, 2);
    req = 1'b0;
    tick(6);
  endtask

  task automatic test_reset_mid();
    int p0;
    int lat;
    p0 = rd_ptr;
    push(32'hC0DE_1234);
    push(32'h0F0F_5A5A);
    tick(1);
    req = 1'b1;
    wait_rd_en(20, lat);
    check_word("rst_pop saw pop", {31'b0, fifo_rd_en}, 32'h1);
    rst = 1'b1;
    #1;
    check_word("rst_pop rd_en", {31'b0, fifo_rd_en}, 32'h0);
    check_word("rst_pop emio", emio_gpio_o, 32'h0);
    req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    // Reset landed before the pop edge, so the first word is still at the head.
    check_word("rst_pop pops", rd_ptr - p0, 0);
    req = 1'b1;
    shift_word(32'hC0DE_1234, 17, "rst_bit17");
    rst = 1'b1;
    #1;
    check_word("rst_bit17 rd_en", {31'b0, fifo_rd_en}, 32'h0);
    check_word("rst_bit17 emio", emio_gpio_o, 32'h0);
    req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    req = 1'b1;
    shift_word(32'h0F0F_5A5A, 32, "after_rst");
    check_word("rst pops", rd_ptr - p0, 2);
    req = 1'b0;
    tick(6);
  endtask

  task automatic test_sclk_ignored();
    int p0;
    p0 = rd_ptr;
    push(32'h8000_0001 ^ $urandom);
    tick(2);
    repeat (10) begin
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      tick(4);
    end
    check_word("idle sclk pops", rd_ptr - p0, 0);
    check_word("idle sclk emio", emio_gpio_o, 32'h0);
    req = 1'b1;
    shift_word(mem[p0[5:0]], 32, "idle_sclk_word");
    repeat (10) begin
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      tick(4);
    end
    check_word("done sclk pops", rd_ptr - p0, 1);
    check_word("done sclk emio", emio_gpio_o, 32'hC);
    req = 1'b0;
    tick(6);
    check_word("final idle emio", emio_gpio_o, 32'h4);
  endtask

  task automatic test_random_words();
    logic [WORD_W-1:0] w;
    int p0;
    for (int k = 0; k < 3; k++) begin
      p0 = rd_ptr;
      w = $urandom;
      push(w);
      tick(1);
      req = 1'b1;
      shift_word(w, 32, "random");
      check_word("random pops", rd_ptr - p0, 1);
      req = 1'b0;
      tick(5);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty_wait();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_sclk_ignored();
    test_random_words();
    check_word("fifo underflow", underflow, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_to_gpio.md
Name: fifo_to_gpio

Overview:
Readback path from PL to PS over the EMIO GPIO bank. The block pops 32-bit words from a standard (non-FWFT) FIFO and serialises each word MSB-first onto a GPIO output bit. The PS bit-bangs the transfer with a request line and a serial clock. It sits downstream of the PL capture FIFO and mirrors the PS-to-PL serial write path in the opposite direction.

Parameters:
REQ_BIT, 0, index in emio_gpio_i of the PS word-request line (level)
SCLK_BIT, 1, index in emio_gpio_i of the PS serial clock
SYNC_STAGES, 2, flop stages on each GPIO input (minimum 2)
WORD_W, 32, FIFO word width and bits shifted per word

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
emio_gpio_i  in  32  PS GPIO outputs; only REQ_BIT and SCLK_BIT are used
emio_gpio_o  out  32  PS GPIO inputs: [0]=sdata, [1]=word_valid, [2]=fifo_empty (synchronised copy), [3]=busy, [31:4]=0
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  WORD_W  FIFO read data, valid exactly 1 clk after fifo_rd_en
fifo_rd_en  out  1  FIFO pop strobe, one clk wide

Behaviour:
- Reset (async, active-high): state=IDLE, shift register=0, bit count=0, fifo_rd_en=0, emio_gpio_o=0. All synchroniser flops clear to 0.
- Inputs: req_s and sclk_s are the SYNC_STAGES-synchronised copies of the GPIO bits. sclk_rise = sclk_s & ~sclk_s_d, where sclk_s_d is a further registered copy.
- State IDLE: busy=0, word_valid=0.
  - If req_s=1 and fifo_empty=0, go to POP.
  - If req_s=1 and fifo_empty=1, stay in IDLE; the PS polls emio_gpio_o[2].
- State POP: fifo_rd_en=1 for this single cycle, then go to LOAD. Never pop while fifo_empty=1.
- State LOAD: shreg <= fifo_dout, cnt <= 0, go to SHIFT. fifo_rd_en=0.
- State SHIFT: word_valid=1, busy=1, sdata=shreg[WORD_W-1].
  - On sclk_rise: shreg <= shreg<<1 (zero fill) and cnt <= cnt+1.
  - When the 32nd sclk_rise is accepted (cnt==WORD_W-1 at that edge), go to DONE.
- State DONE: word_valid=0, busy=1, sdata=0. When req_s=0, go to IDLE. Each word therefore needs a fresh low-then-high req cycle.
- Abort: if req_s drops in SHIFT before 32 edges, go to IDLE. The remaining bits are discarded and no re-pop occurs.
- An sclk_rise outside SHIFT is ignored. An sclk_rise coinciding with req_s falling in SHIFT is also ignored, because abort has priority.
- Latency: req pin high -> fifo_rd_en high takes SYNC_STAGES+1 clks (IDLE evaluation plus POP). First data bit appears on sdata 2 clks after the POP cycle (LOAD, then registered output).
- All emio_gpio_o bits are registered, with no combinational path from the inputs.
- Reset mid-transfer: fifo_rd_en falls immediately (async) and the word in flight is lost. This is documented behaviour.
- Simultaneous fifo_empty rise and POP: a pop is only issued if fifo_empty was 0 in the IDLE cycle. The FIFO protects itself against underflow.
- cnt is $clog2(WORD_W)+1 bits wide and never wraps.

Test Plan:
1. FIFO holds 0xA5C3_0F81; raise req, issue 32 sclk pulses of 8 clks high/8 low -> one fifo_rd_en pulse. sdata sampled before each rise reads 0xA5C30F81 MSB-first. word_valid falls after the 32nd rise. Lowering req returns the block to IDLE with busy=0.
2. FIFO empty, req high for 50 clks -> fifo_rd_en never asserts and emio_gpio_o[2]=1. Push 0x0000_0001 -> pop occurs SYNC_STAGES+1 clks or less after empty falls; LSB appears as the last bit.
3. Back-to-back words 0xFFFF_FFFF and 0x0000_0000 with a req low/high between them -> exactly two pops, correct bit streams, and no pop while req is held high in DONE.
4. Abort: drop req after 10 sclk rises of 0x1234_5678 -> IDLE within SYNC_STAGES+1 clks. The next request pops and serialises the next FIFO word, not the remainder.
5. Assert rst during POP and again at bit 17 -> fifo_rd_en and emio_gpio_o go to 0 asynchronously. After release the state is IDLE, and req low then high pops the next word.
6. sclk toggled while in IDLE and DONE -> no shift and no pop; outputs unchanged.
